// File: rtl/vga_pkg.sv
// Shared encodings for the VGA test-pattern generator: mode codes, 3-bit colour codes
// (bit 2 = red, bit 1 = green, bit 0 = blue) and the default active resolution.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam logic [1:0] MODE_CHECK = 2'd0;
  localparam logic [1:0] MODE_STAR  = 2'd1;
  localparam logic [1:0] MODE_BARS  = 2'd2;
  localparam logic [1:0] MODE_GRAD  = 2'd3;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/star_lfsr.sv
// Galois LFSR (left-shifting, feedback mask TAPS) with step enable, synchronous seed load
// and recovery from the illegal all-zero state.
module star_lfsr #(
  parameter int             W         = 16,
  parameter logic [W-1:0]   TAPS      = W'(16'h100B),
  parameter logic [W-1:0]   RESET_VAL = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] stepped;

  assign stepped = {state[W-2:0], 1'b0} ^ (state[W-1] ? TAPS : '0);

  // Load wins so a frame start always restarts the sequence; a zero state is
  // otherwise a dead end for a Galois LFSR, so it is kicked back to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed;
    end else if (state == '0) begin
      state <= ONE;
    end else if (en) begin
      state <= stepped;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Frame-synchronised test-pattern generator with a two-stage RGB pipeline and matching sync delay.
// Define VGA_PATTERN_SCROLL_EN to scroll the checker and bar patterns one pixel per frame.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int                H_ACTIVE   = DEF_H_ACTIVE,
  parameter int                V_ACTIVE   = DEF_V_ACTIVE,
  parameter int                COLOR_W    = 4,
  parameter int                BORDER     = 20,
  parameter int                CHECK_LOG2 = 3,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(16'h100B),
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_W'(16'hACE1),
  parameter int                STAR_BITS  = 7,
  parameter int                FCNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               display_on_i,
  input  logic [9:0]         hpos_i,
  input  logic [9:0]         vpos_i,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [FCNT_W-1:0]  frame_cnt_o,
  output logic [1:0]         mode_o
);

  localparam int NUM_BARS = 8;
  localparam int BAR_W    = H_ACTIVE / NUM_BARS;
  localparam int GRAD_MAX = (1 << COLOR_W) - 1;

  localparam logic [LFSR_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : LFSR_SEED;
  // Ones in every bit below the star-detect field, so the AND-reduce tests only the top bits.
  localparam logic [LFSR_W-1:0] LOW_MASK =
    {{STAR_BITS{1'b0}}, {(LFSR_W-STAR_BITS){1'b1}}};

  logic               fs;
  logic [1:0]         mode_eff;
  logic               lfsr_en;
  logic [LFSR_W-1:0]  lfsr;
  logic               star_on;
  logic [2:0]         star_pat;
  logic               in_range;
  logic [2:0]         check_pat;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_pat;
  logic [COLOR_W-1:0] grad;
  logic [2:0]         pat;
  logic               grad_sel;
  int                 h;
  int                 v;
  int                 h_scr;

  logic               s1_de;
  logic [2:0]         s1_pat;
  logic [COLOR_W-1:0] s1_grad;
  logic               s1_grad_sel;
  logic               s1_hs;
  logic               s1_vs;

  // The frame-start pixel already uses the mode being latched on that cycle.
  assign fs       = display_on_i && (hpos_i == '0) && (vpos_i == '0);
  assign mode_eff = fs ? mode_i : mode_o;
  assign lfsr_en  = display_on_i && (mode_o == MODE_STAR);

  star_lfsr #(
    .W         (LFSR_W),
    .TAPS      (LFSR_TAPS),
    .RESET_VAL (SEED_EFF)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .load  (fs),
    .seed  (SEED_EFF),
    .state (lfsr)
  );

  assign star_on  = &(lfsr | LOW_MASK);
  assign star_pat = star_on ? lfsr[2:0] : BLACK;

  always_comb begin
    h = int'(hpos_i);
    v = int'(vpos_i);
`ifdef VGA_PATTERN_SCROLL_EN
    h_scr = (h + int'(frame_cnt_o)) % H_ACTIVE;
`else
    h_scr = h;
`endif
    in_range = (h < H_ACTIVE) && (v < V_ACTIVE);

    // Frame lines and margin use the raw position; only the checker content scrolls.
    if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) begin
      check_pat = RED;
    end else if (h == 5 || h == H_ACTIVE - 6 || v == 5 || v == V_ACTIVE - 6) begin
      check_pat = GREEN;
    end else if (h == 10 || h == H_ACTIVE - 11 || v == 10 || v == V_ACTIVE - 11) begin
      check_pat = BLUE;
    end else if (h < BORDER || h >= H_ACTIVE - BORDER ||
                 v < BORDER || v >= V_ACTIVE - BORDER) begin
      check_pat = BLACK;
    end else begin
      check_pat = {1'b0, vpos_i[CHECK_LOG2+1], h_scr[CHECK_LOG2] ^ vpos_i[CHECK_LOG2]};
    end

    // Threshold chains stand in for division by a constant; the last bar absorbs the remainder.
    bar_idx = '0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (h_scr >= i * BAR_W) bar_idx = 3'(i);
    end
    bar_pat = WHITE - bar_idx;

    grad = '0;
    for (int k = 1; k <= GRAD_MAX; k++) begin
      if ((h << COLOR_W) >= k * H_ACTIVE) grad = COLOR_W'(k);
    end
  end

  always_comb begin
    pat      = BLACK;
    grad_sel = 1'b0;
    case (mode_eff)
      MODE_CHECK: pat = check_pat;
      MODE_STAR:  pat = star_pat;
      MODE_BARS:  pat = bar_pat;
      MODE_GRAD:  grad_sel = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_o      <= MODE_CHECK;
      frame_cnt_o <= '0;
    end else if (fs) begin
      mode_o      <= mode_i;
      frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_de       <= 1'b0;
      s1_pat      <= BLACK;
      s1_grad     <= '0;
      s1_grad_sel <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
    end else begin
      s1_de       <= display_on_i && in_range;
      s1_pat      <= pat;
      s1_grad     <= grad;
      s1_grad_sel <= grad_sel;
      s1_hs       <= hsync_i;
      s1_vs       <= vsync_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_hs <= s1_hs;
      vga_vs <= s1_vs;
      if (!s1_de) begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end else if (s1_grad_sel) begin
        vga_r <= s1_grad;
        vga_g <= s1_grad;
        vga_b <= s1_grad;
      end else begin
        vga_r <= {COLOR_W{s1_pat[2]}};
        vga_g <= {COLOR_W{s1_pat[1]}};
        vga_b <= {COLOR_W{s1_pat[0]}};
      end
    end
  end

endmodule
